// File: rtl/poly_tone_gen.sv
// Three-voice square-wave tone generator driven by one-hot note vectors.
// Voices are mixed into a 2-bit level and a 3-clock-frame PWM stream.
module poly_tone_gen #(
    parameter int CLK_HZ = 10000000,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [11:0] note_1,
    input  logic [11:0] note_2,
    input  logic [11:0] note_3,
    output logic [2:0]  voice_active,
    output logic [2:0]  wave,
    output logic [1:0]  mix_level,
    output logic        pwm_out
);

    // Half-period in clocks for semitone s above C4 (s = 11 - bit index).
    function automatic int half_of(input int s);
        real freq;
        freq = 261.6256 * (2.0 ** (real'(s) / 12.0));
        return $rtoi(real'(CLK_HZ) / (2.0 * freq) + 0.5);
    endfunction

    localparam int HALF_MAX = half_of(0);

    if ($clog2(HALF_MAX) > CNT_W) begin : g_cnt_w_check
        $error("poly_tone_gen: CNT_W too narrow for the half-period table");
    end

    logic [CNT_W-1:0] half_tbl [12];

    for (genvar s = 0; s < 12; s++) begin : g_tbl
        localparam int H = half_of(s);
        assign half_tbl[s] = CNT_W'(H);
    end

    logic [11:0] note_in [3];
    assign note_in[0] = note_1;
    assign note_in[1] = note_2;
    assign note_in[2] = note_3;

    for (genvar v = 0; v < 3; v++) begin : g_voice
        logic [11:0]      note_q;
        logic [11:0]      note_qq;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] half_sel;
        logic             wave_r;
        logic             active_r;
        logic             valid;
        logic             changed;

        always_comb begin
            half_sel = '0;
            for (int b = 0; b < 12; b++) begin
                if (note_q[b]) half_sel = half_tbl[11 - b];
            end
        end

        assign valid   = $onehot(note_q);
        assign changed = (note_q != note_qq);

        // Silence, disable and note change all restart the voice at phase 0.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                note_q   <= '0;
                note_qq  <= '0;
                cnt      <= '0;
                wave_r   <= 1'b0;
                active_r <= 1'b0;
            end else begin
                note_q   <= note_in[v];
                note_qq  <= note_q;
                active_r <= ena & valid;
                if (!ena || !valid || changed) begin
                    cnt    <= '0;
                    wave_r <= 1'b0;
                end else if (cnt == half_sel - CNT_W'(1)) begin
                    cnt    <= '0;
                    wave_r <= ~wave_r;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign wave[v]         = wave_r;
        assign voice_active[v] = active_r;
    end

    logic [1:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 2'd0;
            mix_level <= 2'd0;
            pwm_out   <= 1'b0;
        end else begin
            frame_cnt <= (frame_cnt == 2'd2) ? 2'd0 : frame_cnt + 2'd1;
            mix_level <= {1'b0, wave[0]} + {1'b0, wave[1]} + {1'b0, wave[2]};
            pwm_out   <= (frame_cnt < mix_level);
        end
    end

endmodule

// File: tb/tb_poly_tone_gen.sv
// Self-checking bench for poly_tone_gen: timestamp-based voice model plus
// directed timing checks and randomized note/enable sequences.
module tb_poly_tone_gen;
    localparam int CLK_HZ = 10000000;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [11:0] note_1, note_2, note_3;
    logic [2:0]  voice_active;
    logic [2:0]  wave;
    logic [1:0]  mix_level;
    logic        pwm_out;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    poly_tone_gen #(.CLK_HZ(CLK_HZ), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .note_1       (note_1),
        .note_2       (note_2),
        .note_3       (note_3),
        .voice_active (voice_active),
        .wave         (wave),
        .mix_level    (mix_level),
        .pwm_out      (pwm_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int half_of(input int s);
        real f;
        f = 261.6256 * (2.0 ** (real'(s) / 12.0));
        return $rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5);
    endfunction

    function automatic int note_half(input logic [11:0] n);
        for (int b = 0; b < 12; b++) if (n[b]) return half_of(11 - b);
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a voice's wave is determined by clocks elapsed since its last restart.
    longint      edge_n;
    longint      m_start [3];
    logic [11:0] m_nq [3];
    logic [11:0] m_nqq [3];
    logic [2:0]  m_wave, m_act;
    int          m_mix, m_frame;
    logic        m_pwm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n  = 0;
            m_wave  = '0;
            m_act   = '0;
            m_mix   = 0;
            m_frame = 0;
            m_pwm   = 1'b0;
            for (int v = 0; v < 3; v++) begin
                m_start[v] = 0;
                m_nq[v]    = '0;
                m_nqq[v]   = '0;
            end
        end else begin
            logic [11:0] ins [3];
            edge_n++;
            m_pwm   = (m_frame < m_mix);
            m_mix   = $countones(m_wave);
            m_frame = (m_frame + 1) % 3;
            for (int v = 0; v < 3; v++) begin
                bit valid;
                valid = ($countones(m_nq[v]) == 1);
                if (!ena || !valid || (m_nq[v] != m_nqq[v])) begin
                    m_start[v] = edge_n;
                    m_wave[v]  = 1'b0;
                end else begin
                    m_wave[v] = ((edge_n - m_start[v]) / note_half(m_nq[v])) % 2 == 1;
                end
                m_act[v] = ena && valid;
            end
            ins[0] = note_1;
            ins[1] = note_2;
            ins[2] = note_3;
            for (int v = 0; v < 3; v++) begin
                m_nqq[v] = m_nq[v];
                m_nq[v]  = ins[v];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en)
            check("cycle {active,wave,mix,pwm}",
                  {23'd0, voice_active, wave, mix_level, pwm_out},
                  {23'd0, m_act, m_wave, 2'(m_mix), m_pwm});
    end

    function automatic logic [11:0] rand_note();
        int r;
        logic [11:0] n;
        r = $urandom_range(0, 5);
        if (r == 0) n = 12'h000;
        else if (r == 1) n = 12'h0C0;
        else begin
            n = 12'h001;
            n = n << $urandom_range(0, 11);
        end
        return n;
    endfunction

    int n;

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        note_1 = '0;
        note_2 = '0;
        note_3 = '0;

        check("half C4", half_of(0), 19111);
        check("half A4", half_of(9), 11364);
        check("half B4", half_of(11), 10124);

        repeat (3) @(negedge clk);
        check("reset outputs", {24'd0, voice_active, wave, mix_level, pwm_out}, 0);
        rst_n  = 1'b1;
        cmp_en = 1;

        // A4 single voice
        @(negedge clk);
        ena    = 1'b1;
        note_1 = 12'h004;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wave[0] && n < 20000);
        check("A4 first rise", n, 11366);
        check("A4 active", voice_active, 3'b001);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wave[0] && n < 20000);
        check("A4 half period", n, 11364);

        // Asynchronous reset mid-tone
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async reset", {24'd0, voice_active, wave, mix_level, pwm_out}, 0);
        @(negedge clk);
        note_1 = '0;
        ena    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Chord, invalid voice, then note change on voice 0
        @(negedge clk);
        ena    = 1'b1;
        note_1 = 12'h800;
        note_2 = 12'h080;
        note_3 = 12'h010;
        repeat (10) @(negedge clk);
        check("chord active", voice_active, 3'b111);
        repeat (5000) @(negedge clk);
        note_2 = 12'h0C0;
        repeat (3) @(negedge clk);
        check("multi-hot active", voice_active, 3'b101);
        repeat (2000) @(negedge clk);
        check("multi-hot wave1", wave[1], 1'b0);
        repeat (23000) @(negedge clk);
        note_1 = 12'h001;
        @(negedge clk);
        @(negedge clk);
        check("change forces wave0", wave[0], 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wave[0] && n < 20000);
        check("B4 toggle after change", n, 10124);

        // Enable gating during chord
        note_2 = 12'h080;
        repeat (1000) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        check("gate wave", wave, 3'b000);
        @(negedge clk);
        check("gate mix", mix_level, 2'd0);
        @(negedge clk);
        check("gate pwm", pwm_out, 1'b0);
        repeat (2) @(negedge clk);
        ena = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wave[0] && n < 20000);
        check("restart after ena", n, 10124);

        // Randomized notes, enables and one mid-run reset
        for (int seg = 0; seg < 5; seg++) begin
            @(negedge clk);
            note_1 = rand_note();
            note_2 = ($urandom_range(0, 3) == 0) ? note_1 : rand_note();
            note_3 = rand_note();
            ena    = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(300, 900)) @(negedge clk);
            if (seg == 3) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                ena = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                ena = 1'b1;
            end
            repeat ($urandom_range(300, 900)) @(negedge clk);
        end

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
